// File: rtl/johnson_pkg.sv
// Shared FSM encoding and elaboration-time width helper for the Johnson decoder.
package johnson_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_e;

    // Ceiling log2, used to derive counter widths and to check IDX_W.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/johnson_code_to_index.sv
// Combinational Johnson code to binary index converter with legality flag.
module johnson_code_to_index #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned IDX_W  = 3
) (
    input  logic [STAGES-1:0] code_i,
    output logic              legal_o,
    output logic [IDX_W-1:0]  idx_o
);

    // Code at position k: k ones from the LSB up to k=STAGES, then zeros fill from the LSB.
    function automatic logic [STAGES-1:0] code_of(input int unsigned k);
        logic [STAGES-1:0] c;
        c = '0;
        for (int unsigned b = 0; b < STAGES; b++) begin
            if ((k <= STAGES) ? (b < k) : (b >= k - STAGES)) begin
                c = c | (STAGES'(1) << b);
            end
        end
        return c;
    endfunction

    // Match the input against every legal code; all 2*STAGES codes are distinct.
    always_comb begin
        legal_o = 1'b0;
        idx_o   = '0;
        for (int unsigned k = 0; k < 2 * STAGES; k++) begin
            if (code_i == code_of(k)) begin
                legal_o = 1'b1;
                idx_o   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/johnson_sequence_decoder.sv
// Johnson code supervisor: decodes sampled codes, checks steps, tracks lock and errors.
module johnson_sequence_decoder
    import johnson_pkg::*;
#(
    parameter int unsigned STAGES   = 4,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned ERR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] code_in,
    input  logic              code_valid,
    output logic [IDX_W-1:0]  index_out,
    output logic              index_valid,
    output logic              dir_up,
    output logic              dir_down,
    output logic              illegal,
    output logic              step_err,
    output logic              locked,
    output logic [ERR_W-1:0]  err_count
);

    localparam int unsigned     SEQ_LEN  = 2 * STAGES;
    localparam int unsigned     CNT_W    = clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    if (IDX_W != clog2(SEQ_LEN)) begin : g_idx_w_check
        $error("IDX_W must equal clog2(2*STAGES)");
    end

    logic              legal_c;
    logic [IDX_W-1:0]  idx_c;
    int unsigned       delta_c;
    logic              up_c;
    logic              down_c;
    logic              step_err_c;
    logic              fail_c;
    logic [ERR_W-1:0]  err_d;

    state_e            state_q;
    logic [CNT_W-1:0]  good_cnt_q;
    logic [IDX_W-1:0]  prev_idx_q;
    logic              prev_ok_q;
    logic [IDX_W-1:0]  index_q;
    logic              index_valid_q;
    logic              dir_up_q;
    logic              dir_down_q;
    logic              illegal_q;
    logic              step_err_q;
    logic              locked_q;
    logic [ERR_W-1:0]  err_q;

    johnson_code_to_index #(
        .STAGES (STAGES),
        .IDX_W  (IDX_W)
    ) u_decode (
        .code_i  (code_in),
        .legal_o (legal_c),
        .idx_o   (idx_c)
    );

    // Step classification against the previous legal index, plus saturating error increment.
    always_comb begin
        delta_c    = (32'(idx_c) + SEQ_LEN - 32'(prev_idx_q)) % SEQ_LEN;
        up_c       = legal_c && prev_ok_q && (delta_c == 1);
        down_c     = legal_c && prev_ok_q && (delta_c == SEQ_LEN - 1);
        step_err_c = legal_c && prev_ok_q && (delta_c != 0) && !up_c && !down_c;
        fail_c     = !legal_c || step_err_c;
        err_d      = err_q;
        if (fail_c && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    // Sample registers, registered pulses and the lock FSM; only code_valid cycles advance state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= UNLOCKED;
            good_cnt_q    <= '0;
            prev_idx_q    <= '0;
            prev_ok_q     <= 1'b0;
            index_q       <= '0;
            index_valid_q <= 1'b0;
            dir_up_q      <= 1'b0;
            dir_down_q    <= 1'b0;
            illegal_q     <= 1'b0;
            step_err_q    <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= '0;
        end else begin
            index_valid_q <= 1'b0;
            dir_up_q      <= 1'b0;
            dir_down_q    <= 1'b0;
            illegal_q     <= 1'b0;
            step_err_q    <= 1'b0;
            if (code_valid) begin
                err_q     <= err_d;
                illegal_q <= !legal_c;
                if (legal_c) begin
                    index_q       <= idx_c;
                    index_valid_q <= 1'b1;
                    prev_idx_q    <= idx_c;
                    prev_ok_q     <= 1'b1;
                    dir_up_q      <= up_c;
                    dir_down_q    <= down_c;
                    step_err_q    <= step_err_c;
                end else begin
                    prev_ok_q <= 1'b0;
                end
                case (state_q)
                    UNLOCKED: begin
                        if (legal_c) begin
                            good_cnt_q <= CNT_W'(1);
                            if (LOCK_CNT == 1) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                state_q <= ACQUIRE;
                            end
                        end
                    end
                    ACQUIRE: begin
                        if (fail_c) begin
                            state_q    <= UNLOCKED;
                            good_cnt_q <= '0;
                        end else begin
                            good_cnt_q <= good_cnt_q + CNT_W'(1);
                            if (good_cnt_q + CNT_W'(1) == LOCK_TGT) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (fail_c) begin
                            state_q    <= UNLOCKED;
                            good_cnt_q <= '0;
                            locked_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q    <= UNLOCKED;
                        good_cnt_q <= '0;
                        locked_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign index_out   = index_q;
    assign index_valid = index_valid_q;
    assign dir_up      = dir_up_q;
    assign dir_down    = dir_down_q;
    assign illegal     = illegal_q;
    assign step_err    = step_err_q;
    assign locked      = locked_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_johnson_sequence_decoder.sv
// Scoreboard bench for johnson_sequence_decoder with hand-computed directed vectors.
module tb_johnson_sequence_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] code_in;
    logic       code_valid;
    logic [2:0] index_out;
    logic       index_valid;
    logic       dir_up;
    logic       dir_down;
    logic       illegal;
    logic       step_err;
    logic       locked;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       iv;
        logic [2:0] idx;
        logic       up;
        logic       dn;
        logic       ill;
        logic       se;
        logic       lk;
        logic [7:0] ec;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    johnson_sequence_decoder #(
        .STAGES   (4),
        .IDX_W    (3),
        .LOCK_CNT (3),
        .ERR_W    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .code_in     (code_in),
        .code_valid  (code_valid),
        .index_out   (index_out),
        .index_valid (index_valid),
        .dir_up      (dir_up),
        .dir_down    (dir_down),
        .illegal     (illegal),
        .step_err    (step_err),
        .locked      (locked),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // Drive one valid sample and queue the response expected on the following cycle.
    task automatic send(input logic [3:0] c, input logic iv, input int idx, input logic up,
                        input logic dn, input logic ill, input logic se, input logic lk,
                        input int ec);
        exp_t e;
        @(negedge clk);
        code_in    = c;
        code_valid = 1'b1;
        e.iv  = iv;
        e.idx = 3'(idx);
        e.up  = up;
        e.dn  = dn;
        e.ill = ill;
        e.se  = se;
        e.lk  = lk;
        e.ec  = 8'(ec);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            code_valid = 1'b0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_index"}, index_out, 0);
        chk({tag, "_pulses"}, {index_valid, dir_up, dir_down, illegal, step_err}, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_err"}, err_count, 0);
    endtask

    // Monitor: every output pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (!rst && (index_valid || illegal || dir_up || dir_down || step_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual iv=%0d ill=%0d up=%0d dn=%0d se=%0d required none t=%0t",
                         index_valid, illegal, dir_up, dir_down, step_err, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("index_valid", index_valid, mon_e.iv);
                chk("index_out", index_out, mon_e.idx);
                chk("dir_up", dir_up, mon_e.up);
                chk("dir_down", dir_down, mon_e.dn);
                chk("illegal", illegal, mon_e.ill);
                chk("step_err", step_err, mon_e.se);
                chk("locked", locked, mon_e.lk);
                chk("err_count", err_count, mon_e.ec);
            end
        end
    end

    initial begin
        rst        = 1'b0;
        code_valid = 1'b0;
        code_in    = 4'b0000;
        #1 rst = 1'b1;
        #2 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Acquire and lock on an up-counting run.
        send(4'b0000, 1, 0, 0, 0, 0, 0, 0, 0);
        send(4'b0001, 1, 1, 1, 0, 0, 0, 0, 0);
        send(4'b0011, 1, 2, 1, 0, 0, 0, 1, 0);
        send(4'b0111, 1, 3, 1, 0, 0, 0, 1, 0);

        // Walk to the top of the sequence, wrap up, then step back down across the wrap.
        send(4'b1111, 1, 4, 1, 0, 0, 0, 1, 0);
        send(4'b1110, 1, 5, 1, 0, 0, 0, 1, 0);
        send(4'b1100, 1, 6, 1, 0, 0, 0, 1, 0);
        send(4'b1000, 1, 7, 1, 0, 0, 0, 1, 0);
        send(4'b0000, 1, 0, 1, 0, 0, 0, 1, 0);
        send(4'b1000, 1, 7, 0, 1, 0, 0, 1, 0);

        // Illegal code while locked at index 2; next legal sample is not step-checked.
        send(4'b0000, 1, 0, 1, 0, 0, 0, 1, 0);
        send(4'b0001, 1, 1, 1, 0, 0, 0, 1, 0);
        send(4'b0011, 1, 2, 1, 0, 0, 0, 1, 0);
        send(4'b0101, 0, 2, 0, 0, 1, 0, 0, 1);
        send(4'b0111, 1, 3, 0, 0, 0, 0, 0, 1);

        // Relock counting down to index 1, then jump by 3.
        send(4'b0011, 1, 2, 0, 1, 0, 0, 0, 1);
        send(4'b0001, 1, 1, 0, 1, 0, 0, 1, 1);
        send(4'b1111, 1, 4, 0, 0, 0, 1, 0, 2);
        idle(2);

        // Saturate the error counter.
        for (int i = 0; i < 300; i++) begin
            send(4'b0101, 0, 4, 0, 0, 1, 0, 0, (3 + i > 255) ? 255 : 3 + i);
        end
        idle(1);

        // Repeated code separated by idle gaps carrying garbage: no pulses, state held.
        send(4'b1111, 1, 4, 0, 0, 0, 0, 0, 255);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            code_valid = 1'b0;
            code_in    = 4'b0101;
            chk("gap1_locked", locked, 0);
            chk("gap1_index", index_out, 4);
            chk("gap1_err", err_count, 255);
        end
        send(4'b1111, 1, 4, 0, 0, 0, 0, 0, 255);
        idle(3);
        send(4'b1111, 1, 4, 0, 0, 0, 0, 1, 255);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            code_valid = 1'b0;
            code_in    = 4'b1010;
            chk("gap2_locked", locked, 1);
            chk("gap2_index", index_out, 4);
        end

        // Fresh start, five errors, lock, then asynchronous reset mid-stream.
        @(negedge clk);
        rst = 1'b1;
        #1 chk_zero("rst2");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send(4'b0101, 0, 0, 0, 0, 1, 0, 0, k);
        end
        send(4'b0000, 1, 0, 0, 0, 0, 0, 0, 5);
        send(4'b0001, 1, 1, 1, 0, 0, 0, 0, 5);
        send(4'b0011, 1, 2, 1, 0, 0, 0, 1, 5);
        idle(2);
        chk("pre_rst_locked", locked, 1);
        chk("pre_rst_err", err_count, 5);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        code_in    = 4'b0111;
        code_valid = 1'b1;
        @(posedge clk);
        #1 chk_zero("rst_over_valid");
        @(negedge clk);
        code_valid = 1'b0;
        rst        = 1'b0;
        send(4'b0011, 1, 2, 0, 0, 0, 0, 0, 0);
        send(4'b0111, 1, 3, 1, 0, 0, 0, 0, 0);
        idle(3);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
